alu_sequencer: RTL and testbench
================================

# alu_sequencer

Multi-cycle issue controller for the 32-bit ALU datapath. Accepts one operation request at a time over a valid/ready handshake, registers the operands and opcode onto the ALU inputs, and holds them for the opcode's latency (clocked multiplier and divider need several cycles). It then captures the 64-bit Hi/Lo result into response registers and presents it until the consumer takes it. The block sits between the control unit and the ALU, in front of the Z_Reg high/low write path.

## Interface
- MUL_CYCLES, 4: cycles the ALU inputs are held for MUL (10000) before capture; legal range 1-63.
- DIV_CYCLES, 8: cycles the ALU inputs are held for DIV (01111) before capture; legal range 1-63.
- clock  in  1  rising-edge clock for all state.
- clear  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  5  ALU opcode.
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- alu_ra  out  32  registered operand A to the ALU.
- alu_rb  out  32  registered operand B to the ALU.
- alu_op  out  5  registered opcode to the ALU.
- alu_hi  in  32  ALU ResultHi.
- alu_lo  in  32  ALU ResultLo.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer takes the response.
- rsp_hi  out  32  captured high word.
- rsp_lo  out  32  captured low word.
- rsp_err  out  1  request rejected by the operation check; always 0 when the check is compiled out.
- busy  out  1  high in EXEC or RESP.

## Operation
- States: IDLE, EXEC, RESP. The FSM uses only these states; any other encoding returns to IDLE.
- IDLE: req_ready=1; alu_ra, alu_rb and alu_op are driven to 0.
- A request is accepted on a rising edge with req_valid & req_ready. On that edge alu_ra, alu_rb and alu_op load req_a, req_b and req_op.
- Latency counter load value L on accept: MUL → MUL_CYCLES; DIV → DIV_CYCLES; every other opcode → 1. The counter width is sized to hold 63.
- EXEC: alu_* are held stable, and the counter decrements once per cycle.
  - At the edge where the counter reaches 1, rsp_hi/rsp_lo load alu_hi/alu_lo, rsp_err loads 0, and the FSM goes to RESP.
  - On that same edge alu_* return to 0.
- RESP: rsp_valid=1, and rsp_hi, rsp_lo and rsp_err are held stable.
  - On the edge with rsp_ready=1 the FSM returns to IDLE and rsp_valid drops.
  - rsp_hi and rsp_lo keep their last value until the next capture.
- Only one request is outstanding at a time. req_ready=0 in EXEC and RESP. A request cannot be accepted on the same edge as the response handshake; req_ready rises the cycle after.
- Opcodes are passed to the ALU unmodified. The sequencer does not compute results.

## Timing
- Reset (clear=0, asynchronous) forces these values regardless of clock:
  - FSM to IDLE.
  - req_ready=1; rsp_valid=0; busy=0; rsp_err=0.
  - rsp_hi, rsp_lo, alu_ra, alu_rb and alu_op = 0.
  - The counter to 0.
- Reset mid-EXEC or mid-RESP abandons the operation; no response is produced.
- Accept at edge N → capture at edge N+L → rsp_valid high from N+L until the handshake edge.
- Minimum request-to-request spacing, with rsp_ready held at 1: L+2 edges.
- rsp_ready is ignored outside RESP. req_valid and the req_* inputs are ignored outside IDLE.

## Configuration
- ALU_SEQ_OPCHK_EN defined: operation check on accept.
  - Legal opcodes: 00011, 00111, 01000, 01001, 01010, 01011, 01111, 10000, 10001, 10010, 10011.
  - A request fails the check if its opcode is outside that list, or if it is DIV with req_b==0.
  - A failing request does not enter EXEC and alu_* stay 0. It goes directly to RESP at the accept edge N: rsp_valid from N, rsp_hi=rsp_lo=0, rsp_err=1.
- ALU_SEQ_OPCHK_EN undefined: no check.
  - Every opcode is issued with the latency rule above.
  - rsp_err is tied to 0.

## Test plan
- ADD: op=00011, A=0x00000005, B=0x00000007, rsp_ready=1 → rsp_valid on the edge after accept; rsp_lo=0x0000000C, rsp_hi=0, busy high for 2 cycles.
- MUL with MUL_CYCLES=4: A=0xFFFFFFFE, B=0x00000003 → alu_* held for exactly 4 cycles; rsp_hi=0xFFFFFFFF, rsp_lo=0xFFFFFFFA.
- Backpressure: ADD response with rsp_ready=0 for 5 cycles → rsp_valid, rsp_lo and req_ready=0 stable throughout; a req_valid pulse during this window is not accepted.
- Reset mid-DIV: clear=0 two cycles after accepting op=01111 → all outputs at reset values immediately; no rsp_valid after release; the next ADD completes normally.
- With ALU_SEQ_OPCHK_EN: op=00000 → rsp_err=1, rsp_hi=rsp_lo=0, alu_op stays 0. DIV with B=0 → rsp_err=1. Without the macro: DIV with B=0 issues for DIV_CYCLES, rsp_err=0.
- Back-to-back: two ROR requests with req_valid and rsp_ready held at 1 → accept edges exactly 3 apart, with responses in order.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// Handshake and ALU-side signal bundle for alu_sequencer.
// slave = the sequencer itself; master = control unit / ALU / response consumer side.
interface alu_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_ra;
  logic [31:0] alu_rb;
  logic [4:0]  alu_op;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_hi;
  logic [31:0] rsp_lo;
  logic        rsp_err;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_a, req_b, alu_hi, alu_lo, rsp_ready,
    output req_ready, alu_ra, alu_rb, alu_op, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
  );

  modport master (
    output req_valid, req_op, req_a, req_b, alu_hi, alu_lo, rsp_ready,
    input  req_ready, alu_ra, alu_rb, alu_op, rsp_valid, rsp_hi, rsp_lo, rsp_err, busy
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle issue controller: holds operands on the ALU for the opcode's latency, then captures Hi/Lo.
// Optional feature macro: ALU_SEQ_OPCHK_EN (reject illegal opcodes and DIV by zero at accept).
module alu_sequencer #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 8
) (
  input  logic           clock,
  input  logic           clear,
  alu_sequencer_if.slave bus
);

  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [5:0] MUL_L  = 6'(MUL_CYCLES);
  localparam logic [5:0] DIV_L  = 6'(DIV_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] ra_q, ra_d;
  logic [31:0] rb_q, rb_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        err_q, err_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        busy_q, busy_d;
  logic        chk_fail_s;

  function automatic logic [5:0] latency_of(input logic [4:0] op);
    logic [5:0] l;
    case (op)
      OP_MUL:  l = MUL_L;
      OP_DIV:  l = DIV_L;
      default: l = 6'd1;
    endcase
    return l;
  endfunction

`ifdef ALU_SEQ_OPCHK_EN
  function automatic logic op_legal(input logic [4:0] op, input logic [31:0] b);
    logic ok;
    case (op)
      5'b00011, 5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
      5'b10000, 5'b10001, 5'b10010, 5'b10011: ok = 1'b1;
      OP_DIV:  ok = (b != 32'd0);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign chk_fail_s = ~op_legal(bus.req_op, bus.req_b);
`else
  assign chk_fail_s = 1'b0;
`endif

  // Next-state and next-register computation for the IDLE/EXEC/RESP controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        ra_d = 32'd0;
        rb_d = 32'd0;
        op_d = 5'd0;
        cnt_d = 6'd0;
        if (bus.req_valid && chk_fail_s) begin
          state_d = ST_RESP;
          hi_d    = 32'd0;
          lo_d    = 32'd0;
          err_d   = 1'b1;
        end else if (bus.req_valid) begin
          state_d = ST_EXEC;
          ra_d    = bus.req_a;
          rb_d    = bus.req_b;
          op_d    = bus.req_op;
          cnt_d   = latency_of(bus.req_op);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Counter value 1 marks the last held cycle; 0 guards against an out-of-range latency.
        if (cnt_q <= 6'd1) begin
          state_d = ST_RESP;
          hi_d    = bus.alu_hi;
          lo_d    = bus.alu_lo;
          err_d   = 1'b0;
          ra_d    = 32'd0;
          rb_d    = 32'd0;
          op_d    = 5'd0;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q - 6'd1;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ra_d    = 32'd0;
        rb_d    = 32'd0;
        op_d    = 5'd0;
        cnt_d   = 6'd0;
      end
    endcase

    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    busy_d      = (state_d != ST_IDLE);
  end

  // State, operand, response and status registers.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 6'd0;
      ra_q        <= 32'd0;
      rb_q        <= 32'd0;
      op_q        <= 5'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      op_q        <= op_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.alu_ra    = ra_q;
  assign bus.alu_rb    = rb_q;
  assign bus.alu_op    = op_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_hi    = hi_q;
  assign bus.rsp_lo    = lo_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed steps plus randomized requests against a timing/result model.
module tb_alu_sequencer;

  localparam int MUL_C = 4;
  localparam int DIV_C = 8;
  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_MUL = 5'b10000;
  localparam logic [4:0] OP_DIV = 5'b01111;
  localparam logic [4:0] OP_ROR = 5'b01001;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_sequencer_if ifc ();

  alu_sequencer #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (ifc.slave)
  );

  always #5 clock = ~clock;

  // Behavioural ALU: signed MUL, unsigned DIV (Hi=remainder, Lo=quotient), ADD, anything else a mix.
  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    case (op)
      OP_ADD:  r = {32'h0, a + b};
      OP_MUL:  r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      OP_DIV:  r = (b == 32'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : {a % b, a / b};
      default: r = {a ^ b, a - b};
    endcase
    return r;
  endfunction

  function automatic int exp_latency(input logic [4:0] op);
    return (op == OP_MUL) ? MUL_C : (op == OP_DIV) ? DIV_C : 1;
  endfunction

  function automatic logic exp_err(input logic [4:0] op, input logic [31:0] b);
`ifdef ALU_SEQ_OPCHK_EN
    int legal [11] = '{3, 7, 8, 9, 10, 11, 15, 16, 17, 18, 19};
    bit found = 1'b0;
    foreach (legal[i]) if (int'(op) == legal[i]) found = 1'b1;
    return !found || (op == OP_DIV && b == 32'd0);
`else
    return 1'b0;
`endif
  endfunction

  assign {ifc.alu_hi, ifc.alu_lo} = alu_model(ifc.alu_op, ifc.alu_ra, ifc.alu_rb);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One request from IDLE through handshake; hold = cycles rsp_ready stays low in RESP.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit pulse);
    logic        e;
    logic [63:0] r;
    int          l;
    int          k;
    e = exp_err(op, b);
    r = e ? 64'd0 : alu_model(op, a, b);
    l = e ? 0 : exp_latency(op);
    ifc.rsp_ready = (hold == 0);
    check("idle_ready", ifc.req_ready, 1'b1);
    ifc.req_valid = 1'b1;
    ifc.req_op    = op;
    ifc.req_a     = a;
    ifc.req_b     = b;
    tick();
    ifc.req_valid = 1'b0;
    ifc.req_op    = 5'($urandom);
    ifc.req_a     = $urandom;
    ifc.req_b     = $urandom;
    check("accept_busy", ifc.busy, 1'b1);
    check("accept_ready", ifc.req_ready, 1'b0);
    k = 0;
    while (!ifc.rsp_valid && k < 100) begin
      check("held_op", ifc.alu_op, op);
      check("held_ra", ifc.alu_ra, a);
      check("held_rb", ifc.alu_rb, b);
      tick();
      k++;
    end
    check("latency", k, l);
    check("rsp_hi", ifc.rsp_hi, r[63:32]);
    check("rsp_lo", ifc.rsp_lo, r[31:0]);
    check("rsp_err", ifc.rsp_err, e);
    check("alu_op_zero", ifc.alu_op, 5'd0);
    check("alu_ra_zero", ifc.alu_ra, 32'd0);
    for (int i = 0; i < hold; i++) begin
      ifc.req_valid = pulse;
      tick();
      check("bp_valid", ifc.rsp_valid, 1'b1);
      check("bp_lo", ifc.rsp_lo, r[31:0]);
      check("bp_ready", ifc.req_ready, 1'b0);
      check("bp_op", ifc.alu_op, 5'd0);
    end
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    tick();
    check("done_valid", ifc.rsp_valid, 1'b0);
    check("done_ready", ifc.req_ready, 1'b1);
    check("done_busy", ifc.busy, 1'b0);
    check("done_lo_kept", ifc.rsp_lo, r[31:0]);
    ifc.rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] a2;
    logic [31:0] b2;
    logic [31:0] lo_q [$];
    int          acc_t [$];
    int          t;
    bit          acc_now;

    ifc.req_valid = 1'b0;
    ifc.req_op    = 5'd0;
    ifc.req_a     = 32'd0;
    ifc.req_b     = 32'd0;
    ifc.rsp_ready = 1'b0;

    // Asynchronous reset before the first clock edge.
    #2 clear = 1'b0;
    #2;
    check("rst_ready", ifc.req_ready, 1'b1);
    check("rst_valid", ifc.rsp_valid, 1'b0);
    check("rst_busy", ifc.busy, 1'b0);
    check("rst_err", ifc.rsp_err, 1'b0);
    check("rst_hilo", {ifc.rsp_hi, ifc.rsp_lo}, 64'd0);
    check("rst_alu", {ifc.alu_ra, ifc.alu_rb, ifc.alu_op}, 69'd0);
    tick();
    tick();
    clear = 1'b1;
    tick();

    // ADD with rsp_ready held high.
    run_op(OP_ADD, 32'h0000_0005, 32'h0000_0007, 0, 1'b0);
    check("add_lo_const", ifc.rsp_lo, 32'h0000_000C);
    check("add_hi_const", ifc.rsp_hi, 32'h0000_0000);

    // MUL signed result.
    run_op(OP_MUL, 32'hFFFF_FFFE, 32'h0000_0003, 0, 1'b0);
    check("mul_hi_const", ifc.rsp_hi, 32'hFFFF_FFFF);
    check("mul_lo_const", ifc.rsp_lo, 32'hFFFF_FFFA);

    // ADD under 5 cycles of backpressure with a stray request pulse.
    run_op(OP_ADD, 32'h1234_0000, 32'h0000_5678, 5, 1'b1);

    // Reset two cycles into a DIV abandons it.
    ifc.req_valid = 1'b1;
    ifc.req_op    = OP_DIV;
    ifc.req_a     = 32'd100;
    ifc.req_b     = 32'd7;
    tick();
    ifc.req_valid = 1'b0;
    tick();
    tick();
    clear = 1'b0;
    #1;
    check("mid_rst_ready", ifc.req_ready, 1'b1);
    check("mid_rst_busy", ifc.busy, 1'b0);
    check("mid_rst_valid", ifc.rsp_valid, 1'b0);
    check("mid_rst_alu", {ifc.alu_ra, ifc.alu_rb, ifc.alu_op}, 69'd0);
    check("mid_rst_hilo", {ifc.rsp_hi, ifc.rsp_lo, ifc.rsp_err}, 65'd0);
    tick();
    clear = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_novalid", ifc.rsp_valid, 1'b0);
    end
    run_op(OP_ADD, 32'd40, 32'd2, 0, 1'b0);

    // DIV by zero: rejected with the check, issued for DIV_CYCLES without it.
    run_op(OP_DIV, 32'd99, 32'd0, 1, 1'b0);
`ifdef ALU_SEQ_OPCHK_EN
    check("div0_err", ifc.rsp_err, 1'b1);
    run_op(5'b00000, 32'd1, 32'd2, 0, 1'b0);
    check("bad_op_err", ifc.rsp_err, 1'b1);
    check("bad_op_hilo", {ifc.rsp_hi, ifc.rsp_lo}, 64'd0);
`else
    check("div0_noerr", ifc.rsp_err, 1'b0);
`endif

    // Back-to-back ROR with req_valid and rsp_ready held high.
    a  = $urandom;
    b  = $urandom;
    a2 = $urandom;
    b2 = $urandom;
    ifc.rsp_ready = 1'b1;
    ifc.req_valid = 1'b1;
    ifc.req_op    = OP_ROR;
    ifc.req_a     = a;
    ifc.req_b     = b;
    t = 0;
    while (t < 40 && lo_q.size() < 2) begin
      acc_now = ifc.req_valid && ifc.req_ready;
      if (ifc.rsp_valid && ifc.rsp_ready) lo_q.push_back(ifc.rsp_lo);
      tick();
      t++;
      if (acc_now) begin
        acc_t.push_back(t);
        if (acc_t.size() == 1) begin
          ifc.req_a = a2;
          ifc.req_b = b2;
        end else begin
          ifc.req_valid = 1'b0;
        end
      end
    end
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b0;
    check("b2b_accepts", acc_t.size(), 2);
    check("b2b_spacing", (acc_t.size() == 2) ? acc_t[1] - acc_t[0] : -1, 3);
    check("b2b_rsps", lo_q.size(), 2);
    check("b2b_rsp0", (lo_q.size() > 0) ? lo_q[0] : 32'hDEAD_BEEF, alu_model(OP_ROR, a, b) & 64'hFFFF_FFFF);
    check("b2b_rsp1", (lo_q.size() > 1) ? lo_q[1] : 32'hDEAD_BEEF, alu_model(OP_ROR, a2, b2) & 64'hFFFF_FFFF);
    tick();

    // Randomized requests.
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0:       op = OP_ADD;
        1:       op = OP_MUL;
        2:       op = OP_DIV;
        default: op = 5'($urandom_range(0, 31));
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(op, a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
